// File: rtl/trunc_avg_sequencer_if.sv
// Bundle between the averaging sequencer, the register-file read/write ports and the shared truncated adder.
// Latency: none, wires only.
// Backpressure: wr_ready exists only with TRUNC_SEQ_STALL_EN defined; otherwise writes are always taken.
interface trunc_avg_sequencer_if #(
    parameter int ADDR_W = 4
);
    logic                     start;
    logic [ADDR_W:0]          len;
    logic                     round;
    logic                     busy;
    logic                     done;
    logic                     rd_en;
    logic [ADDR_W-1:0]        rd_addr;
    logic signed [7:0]        a_data;
    logic signed [7:0]        b_data;
    logic signed [7:0]        add_a;
    logic signed [7:0]        add_b;
    logic                     add_c0;
    logic signed [7:0]        add_sum;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic signed [7:0]        wr_data;
`ifdef TRUNC_SEQ_STALL_EN
    logic                     wr_ready;
`endif

    // Sequencer side.
    modport master (
`ifdef TRUNC_SEQ_STALL_EN
        input  wr_ready,
`endif
        input  start, len, round, a_data, b_data, add_sum,
        output busy, done, rd_en, rd_addr, add_a, add_b, add_c0,
        output wr_en, wr_addr, wr_data
    );

    // Register file / adder / command source side.
    modport slave (
`ifdef TRUNC_SEQ_STALL_EN
        output wr_ready,
`endif
        output start, len, round, a_data, b_data, add_sum,
        input  busy, done, rd_en, rd_addr, add_a, add_b, add_c0,
        input  wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/trunc_avg_sequencer.sv
// Element-wise truncated average of two signed 8-bit vectors via an external adder; optional stall build macro TRUNC_SEQ_STALL_EN.
// Latency: 3 cycles rd_en -> wr_en per element, 1 element/cycle, done N+4 cycles after start is sampled.
// Backpressure: none by default; with TRUNC_SEQ_STALL_EN, wr_ready low freezes reads, operands and writes, a skid entry holds in-flight read data.
module trunc_avg_sequencer #(
    parameter int MAX_LEN = 16,
    parameter int ADDR_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    trunc_avg_sequencer_if.master bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_LEN);

    state_t                state_q, state_d;
    logic [ADDR_W:0]       cnt_q;
    logic [ADDR_W:0]       len_clamped;
    logic [ADDR_W:0]       last_idx;
    logic                  round_q;
    logic [ADDR_W-1:0]     issue_idx_q;
    logic                  rd_issue;
    logic                  start_acc;
    logic                  last_issue;
    logic                  last_write;
    logic                  stall;
    logic                  wr_acc;

    logic                  rd_vld_q;
    logic [ADDR_W-1:0]     rd_idx_q;

    logic                  s2_vld;
    logic signed [7:0]     s2_a, s2_b;
    logic [ADDR_W-1:0]     s2_idx;

    logic                  op_vld_q;
    logic [ADDR_W-1:0]     op_idx_q;
    logic signed [7:0]     add_a_q, add_b_q;

    logic                  wr_en_q;
    logic [ADDR_W-1:0]     wr_addr_q;
    logic signed [7:0]     wr_data_q;

    assign len_clamped = (bus.len > MAX_CNT) ? MAX_CNT : bus.len;
    assign last_idx    = cnt_q - (ADDR_W+1)'(1);
    assign last_issue  = ({1'b0, issue_idx_q} == last_idx);
    assign last_write  = wr_acc && ({1'b0, wr_addr_q} == last_idx);

`ifdef TRUNC_SEQ_STALL_EN
    assign stall  = wr_en_q & ~bus.wr_ready;
    assign wr_acc = wr_en_q & bus.wr_ready;
`else
    assign stall  = 1'b0;
    assign wr_acc = wr_en_q;
`endif

    // Next-state and read-issue decode; reads pause whenever the write stage is stalled.
    always_comb begin
        state_d   = state_q;
        rd_issue  = 1'b0;
        start_acc = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    start_acc = 1'b1;
                    state_d   = (len_clamped == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (!stall) begin
                    rd_issue = 1'b1;
                    if (last_issue) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (last_write) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command latch and read index counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            round_q     <= 1'b0;
            issue_idx_q <= '0;
        end else if (start_acc) begin
            cnt_q       <= len_clamped;
            round_q     <= bus.round;
            issue_idx_q <= '0;
        end else if (rd_issue) begin
            issue_idx_q <= issue_idx_q + ADDR_W'(1);
        end
    end

    // Track which cycle carries returning read data and its element index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q <= 1'b0;
            rd_idx_q <= '0;
        end else begin
            rd_vld_q <= rd_issue;
            if (rd_issue) begin
                rd_idx_q <= issue_idx_q;
            end
        end
    end

`ifdef TRUNC_SEQ_STALL_EN
    logic                  skid_vld_q;
    logic signed [7:0]     skid_a_q, skid_b_q;
    logic [ADDR_W-1:0]     skid_idx_q;

    // Park read data that lands while writes are stalled; it is consumed ahead of any newer read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_vld_q <= 1'b0;
            skid_a_q   <= '0;
            skid_b_q   <= '0;
            skid_idx_q <= '0;
        end else if (stall && rd_vld_q) begin
            skid_vld_q <= 1'b1;
            skid_a_q   <= bus.a_data;
            skid_b_q   <= bus.b_data;
            skid_idx_q <= rd_idx_q;
        end else if (!stall) begin
            skid_vld_q <= 1'b0;
        end
    end
`endif

    // Operand source for the adder stage: skid entry first, else live read data.
    always_comb begin
        s2_vld = rd_vld_q;
        s2_a   = bus.a_data;
        s2_b   = bus.b_data;
        s2_idx = rd_idx_q;
`ifdef TRUNC_SEQ_STALL_EN
        if (skid_vld_q) begin
            s2_vld = 1'b1;
            s2_a   = skid_a_q;
            s2_b   = skid_b_q;
            s2_idx = skid_idx_q;
        end
`endif
    end

    // Adder operand registers; values persist between commands so the adder input stays quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_vld_q <= 1'b0;
            op_idx_q <= '0;
            add_a_q  <= '0;
            add_b_q  <= '0;
        end else if (!stall) begin
            op_vld_q <= s2_vld;
            if (s2_vld) begin
                add_a_q  <= s2_a;
                add_b_q  <= s2_b;
                op_idx_q <= s2_idx;
            end
        end
    end

    // Result write stage: capture the adder output verbatim with its element index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else if (!stall) begin
            wr_en_q <= op_vld_q;
            if (op_vld_q) begin
                wr_addr_q <= op_idx_q;
                wr_data_q <= bus.add_sum;
            end
        end
    end

    assign bus.busy    = (state_q == RUN) || (state_q == DRAIN);
    assign bus.done    = (state_q == DONE);
    assign bus.rd_en   = rd_issue;
    assign bus.rd_addr = issue_idx_q;
    assign bus.add_a   = add_a_q;
    assign bus.add_b   = add_b_q;
    assign bus.add_c0  = round_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
endmodule

// File: tb/tb_trunc_avg_sequencer.sv
// Self-checking bench for trunc_avg_sequencer: random vectors against a cycle-level reference of the element schedule.
// Latency: expects reads at cycles 1..N, writes at k+4, done at N+4 (shifted by stall cycles when stalls are enabled).
// Backpressure: wr_ready is driven only when TRUNC_SEQ_STALL_EN is defined.
module tb_trunc_avg_sequencer;
    localparam int MAX_LEN = 16;
    localparam int ADDR_W  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    trunc_avg_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    trunc_avg_sequencer #(.MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t0       = 0;

    logic signed [7:0] mem_a [MAX_LEN];
    logic signed [7:0] mem_b [MAX_LEN];

    int   rd_cyc[$], rd_adr[$];
    int   wr_cyc[$], wr_adr[$], wr_dat[$];
    int   done_q[$];
    int   busy_cnt, c0_bad;
    logic busy_at_done;
    logic cur_round = 1'b0;

    logic              rd_req = 1'b0;
    logic [ADDR_W-1:0] rd_req_addr = '0;
    logic              wr_go;
    logic [9:0]        add_s;

`ifdef TRUNC_SEQ_STALL_EN
    assign wr_go = bus.wr_ready;
`else
    assign wr_go = 1'b1;
`endif

    // External truncated adder: (a + b + c0) >> 1 on a sign-extended sum.
    assign add_s       = {{2{bus.add_a[7]}}, bus.add_a} + {{2{bus.add_b[7]}}, bus.add_b} + {9'd0, bus.add_c0};
    assign bus.add_sum = add_s[8:1];

    // Register file: data appears the cycle after a read request, noise otherwise.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_req) begin
            bus.a_data <= mem_a[rd_req_addr];
            bus.b_data <= mem_b[rd_req_addr];
        end else begin
            bus.a_data <= 8'($urandom);
            bus.b_data <= 8'($urandom);
        end
    end

    // Monitor on the falling edge, cycle numbers relative to the start cycle.
    always @(negedge clk) begin
        rd_req      = bus.rd_en;
        rd_req_addr = bus.rd_addr;
        if (bus.rd_en === 1'b1) begin
            rd_cyc.push_back(cyc - t0);
            rd_adr.push_back(int'(bus.rd_addr));
        end
        if (bus.wr_en === 1'b1 && wr_go === 1'b1) begin
            wr_cyc.push_back(cyc - t0);
            wr_adr.push_back(int'(bus.wr_addr));
            wr_dat.push_back(int'(bus.wr_data));
        end
        if (bus.busy === 1'b1) begin
            busy_cnt++;
            if (bus.add_c0 !== cur_round) c0_bad++;
        end
        if (bus.done === 1'b1) begin
            if (done_q.size() == 0) busy_at_done = bus.busy;
            done_q.push_back(cyc - t0);
        end
    end

    // Reference arithmetic: floor of the rounded mean.
    function automatic int exp_avg(int k, bit r);
        return (int'(mem_a[k]) + int'(mem_b[k]) + int'(r)) >>> 1;
    endfunction

    task automatic clear_logs();
        rd_cyc.delete(); rd_adr.delete();
        wr_cyc.delete(); wr_adr.delete(); wr_dat.delete();
        done_q.delete();
        busy_cnt = 0; c0_bad = 0; busy_at_done = 1'bx;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < MAX_LEN; i++) begin
            mem_a[i] = 8'($urandom);
            mem_b[i] = 8'($urandom);
        end
    endtask

    // Called just after a rising edge; that cycle becomes cycle 0.
    task automatic start_cmd(int l, bit r);
        clear_logs();
        cur_round = r;
        bus.len   = (ADDR_W+1)'(l);
        bus.round = r;
        bus.start = 1'b1;
        t0        = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Bounded wait for a number of done pulses; optional wr_ready-low window in relative cycles.
    task automatic wait_done(int bound, int want, int slo, int shi);
        for (int i = 0; i < bound && done_q.size() < want; i++) begin
`ifdef TRUNC_SEQ_STALL_EN
            bus.wr_ready = !((cyc - t0) >= slo && (cyc - t0) <= shi);
`endif
            @(posedge clk); #1;
        end
`ifdef TRUNC_SEQ_STALL_EN
        bus.wr_ready = 1'b1;
`endif
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #2;
        checks++;
        if ({bus.busy, bus.done, bus.rd_en, bus.wr_en} !== 4'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0000", {bus.busy, bus.done, bus.rd_en, bus.wr_en});
        end
        checks++;
        if ({bus.add_a, bus.add_b, bus.wr_data, bus.add_c0, bus.rd_addr, bus.wr_addr} !== '0) begin
            failures++;
            $display("FAIL reset_data got a=%0d b=%0d wd=%0d c0=%b ra=%0d wa=%0d exp all 0",
                     bus.add_a, bus.add_b, bus.wr_data, bus.add_c0, bus.rd_addr, bus.wr_addr);
        end
        idle(3);
        rst_n = 1'b1;
        idle(2);
        checks++;
        if ({bus.busy, bus.done, bus.rd_en, bus.wr_en} !== 4'b0) begin
            failures++;
            $display("FAIL reset_idle got=%b exp=0000", {bus.busy, bus.done, bus.rd_en, bus.wr_en});
        end
    endtask

    task automatic test_plan();
        int want0 [4] = '{15, -11, 127, -128};
        int want1 [4] = '{2, -1, 0, 0};
        for (int c = 0; c < 2; c++) begin
            int n;
            bit r;
            n = (c == 0) ? 4 : 2;
            r = (c == 1);
            if (c == 0) begin
                mem_a[0] = 10;  mem_a[1] = -10; mem_a[2] = 127; mem_a[3] = -128;
                mem_b[0] = 20;  mem_b[1] = -11; mem_b[2] = 127; mem_b[3] = -128;
            end else begin
                mem_a[0] = 1;   mem_a[1] = -3;
                mem_b[0] = 2;   mem_b[1] = 0;
            end
            start_cmd(n, r);
            wait_done(100, 1, -1, -1);
            idle(3);
            checks++;
            if (wr_adr.size() != n) begin
                failures++;
                $display("FAIL plan%0d wr_count got=%0d exp=%0d", c, wr_adr.size(), n);
            end
            for (int k = 0; k < n && k < wr_adr.size(); k++) begin
                int w;
                w = (c == 0) ? want0[k] : want1[k];
                checks++;
                if (wr_adr[k] != k || wr_dat[k] != w || wr_cyc[k] != k + 4) begin
                    failures++;
                    $display("FAIL plan%0d wr[%0d] got addr=%0d data=%0d cyc=%0d exp addr=%0d data=%0d cyc=%0d",
                             c, k, wr_adr[k], wr_dat[k], wr_cyc[k], k, w, k + 4);
                end
            end
            checks++;
            if (done_q.size() != 1 || done_q[0] != n + 4 || busy_at_done !== 1'b0) begin
                failures++;
                $display("FAIL plan%0d done got count=%0d cyc=%0d busy=%b exp count=1 cyc=%0d busy=0",
                         c, done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, busy_at_done, n + 4);
            end
            checks++;
            if (c0_bad != 0 || bus.add_c0 !== r) begin
                failures++;
                $display("FAIL plan%0d add_c0 got bad_cycles=%0d hold=%b exp bad_cycles=0 hold=%b", c, c0_bad, bus.add_c0, r);
            end
        end
    endtask

    // Edge lengths and random commands share one cycle-exact schedule check.
    task automatic test_lengths();
        int lens [8] = '{0, 20, 1, 16, 0, 0, 0, 0};
        for (int i = 4; i < 8; i++) lens[i] = $urandom_range(1, 20);
        for (int c = 0; c < 8; c++) begin
            int  l, n;
            bit  r;
            l = lens[c];
            n = (l > MAX_LEN) ? MAX_LEN : l;
            r = 1'($urandom_range(0, 1));
            randomize_mem();
            start_cmd(l, r);
            wait_done(100, 1, -1, -1);
            idle(3);
            checks++;
            if (rd_adr.size() != n || wr_adr.size() != n) begin
                failures++;
                $display("FAIL len%0d counts got rd=%0d wr=%0d exp rd=%0d wr=%0d", l, rd_adr.size(), wr_adr.size(), n, n);
            end
            for (int k = 0; k < n && k < rd_adr.size(); k++) begin
                checks++;
                if (rd_adr[k] != k || rd_cyc[k] != k + 1) begin
                    failures++;
                    $display("FAIL len%0d rd[%0d] got addr=%0d cyc=%0d exp addr=%0d cyc=%0d", l, k, rd_adr[k], rd_cyc[k], k, k + 1);
                end
            end
            for (int k = 0; k < n && k < wr_adr.size(); k++) begin
                checks++;
                if (wr_adr[k] != k || wr_dat[k] != exp_avg(k, r) || wr_cyc[k] != k + 4) begin
                    failures++;
                    $display("FAIL len%0d wr[%0d] got addr=%0d data=%0d cyc=%0d exp addr=%0d data=%0d cyc=%0d",
                             l, k, wr_adr[k], wr_dat[k], wr_cyc[k], k, exp_avg(k, r), k + 4);
                end
            end
            checks++;
            if (done_q.size() != 1 || done_q[0] != ((n == 0) ? 1 : n + 4) || busy_at_done !== 1'b0 ||
                busy_cnt != ((n == 0) ? 0 : n + 3) || c0_bad != 0) begin
                failures++;
                $display("FAIL len%0d done got count=%0d cyc=%0d busy_cycles=%0d c0_bad=%0d exp count=1 cyc=%0d busy_cycles=%0d c0_bad=0",
                         l, done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, busy_cnt, c0_bad,
                         (n == 0) ? 1 : n + 4, (n == 0) ? 0 : n + 3);
            end
        end
    endtask

    task automatic test_abort();
        randomize_mem();
        mem_a[0] = 55;
        start_cmd(8, 1'b1);
        idle(2);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.rd_en, bus.wr_en, bus.add_c0} !== 5'b0 ||
            {bus.add_a, bus.add_b, bus.wr_data, bus.rd_addr, bus.wr_addr} !== '0) begin
            failures++;
            $display("FAIL abort_outputs got busy=%b done=%b rd=%b wr=%b c0=%b a=%0d b=%0d wd=%0d exp all 0",
                     bus.busy, bus.done, bus.rd_en, bus.wr_en, bus.add_c0, bus.add_a, bus.add_b, bus.wr_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_logs();
        t0 = cyc;
        idle(20);
        checks++;
        if (rd_adr.size() != 0 || wr_adr.size() != 0 || done_q.size() != 0 || busy_cnt != 0) begin
            failures++;
            $display("FAIL abort_quiet got rd=%0d wr=%0d done=%0d busy_cycles=%0d exp 0 0 0 0",
                     rd_adr.size(), wr_adr.size(), done_q.size(), busy_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int e_rc[$], e_ra[$], e_wc[$], e_wa[$], e_wd[$];
        randomize_mem();
        start_cmd(4, 1'b0);            // now in cycle 1
        idle(1);                       // cycle 2, busy: this start must be ignored
        bus.start = 1'b1; bus.len = 5'd2;
        idle(1);
        bus.start = 1'b0;
        idle(5);                       // cycle 8: DONE of the first command
        bus.start = 1'b1; bus.len = 5'd3; bus.round = 1'b1; cur_round = 1'b1;
        idle(2);                       // held through cycle 9 (IDLE), dropped in cycle 10
        bus.start = 1'b0;
        wait_done(60, 2, -1, -1);
        idle(3);
        for (int k = 0; k < 4; k++) begin
            e_rc.push_back(k + 1);  e_ra.push_back(k);
            e_wc.push_back(k + 4);  e_wa.push_back(k); e_wd.push_back(exp_avg(k, 1'b0));
        end
        for (int k = 0; k < 3; k++) begin
            e_rc.push_back(k + 10); e_ra.push_back(k);
            e_wc.push_back(k + 13); e_wa.push_back(k); e_wd.push_back(exp_avg(k, 1'b1));
        end
        checks++;
        if (rd_adr.size() != 7 || wr_adr.size() != 7) begin
            failures++;
            $display("FAIL b2b counts got rd=%0d wr=%0d exp rd=7 wr=7", rd_adr.size(), wr_adr.size());
        end
        for (int k = 0; k < 7 && k < rd_adr.size() && k < wr_adr.size(); k++) begin
            checks++;
            if (rd_adr[k] != e_ra[k] || rd_cyc[k] != e_rc[k] || wr_adr[k] != e_wa[k] ||
                wr_cyc[k] != e_wc[k] || wr_dat[k] != e_wd[k]) begin
                failures++;
                $display("FAIL b2b elem[%0d] got rd=%0d@%0d wr=%0d@%0d data=%0d exp rd=%0d@%0d wr=%0d@%0d data=%0d",
                         k, rd_adr[k], rd_cyc[k], wr_adr[k], wr_cyc[k], wr_dat[k], e_ra[k], e_rc[k], e_wa[k], e_wc[k], e_wd[k]);
            end
        end
        checks++;
        if (done_q.size() != 2 || done_q[0] != 8 || done_q[1] != 16) begin
            failures++;
            $display("FAIL b2b done got count=%0d first=%0d second=%0d exp count=2 first=8 second=16",
                     done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, (done_q.size() > 1) ? done_q[1] : -1);
        end
    endtask

`ifdef TRUNC_SEQ_STALL_EN
    task automatic test_stall();
        int e_rc [6] = '{1, 2, 3, 4, 8, 9};
        int e_wc [6] = '{4, 8, 9, 10, 11, 12};
        int stall_reads;
        randomize_mem();
        start_cmd(6, 1'b0);
        wait_done(100, 1, 5, 7);
        idle(3);
        stall_reads = 0;
        foreach (rd_cyc[i]) if (rd_cyc[i] >= 5 && rd_cyc[i] <= 7) stall_reads++;
        checks++;
        if (rd_adr.size() != 6 || wr_adr.size() != 6 || stall_reads != 0) begin
            failures++;
            $display("FAIL stall counts got rd=%0d wr=%0d rd_in_stall=%0d exp rd=6 wr=6 rd_in_stall=0",
                     rd_adr.size(), wr_adr.size(), stall_reads);
        end
        for (int k = 0; k < 6 && k < rd_adr.size() && k < wr_adr.size(); k++) begin
            checks++;
            if (rd_adr[k] != k || rd_cyc[k] != e_rc[k] || wr_adr[k] != k ||
                wr_cyc[k] != e_wc[k] || wr_dat[k] != exp_avg(k, 1'b0)) begin
                failures++;
                $display("FAIL stall elem[%0d] got rd=%0d@%0d wr=%0d@%0d data=%0d exp rd=%0d@%0d wr=%0d@%0d data=%0d",
                         k, rd_adr[k], rd_cyc[k], wr_adr[k], wr_cyc[k], wr_dat[k], k, e_rc[k], k, e_wc[k], exp_avg(k, 1'b0));
            end
        end
        checks++;
        if (done_q.size() != 1 || done_q[0] != 13) begin
            failures++;
            $display("FAIL stall done got count=%0d cyc=%0d exp count=1 cyc=13",
                     done_q.size(), (done_q.size() > 0) ? done_q[0] : -1);
        end
    endtask
`endif

    initial begin
        bus.start = 1'b0;
        bus.len   = '0;
        bus.round = 1'b0;
`ifdef TRUNC_SEQ_STALL_EN
        bus.wr_ready = 1'b1;
`endif
        clear_logs();
        randomize_mem();
        test_reset();
        test_plan();
        test_lengths();
        test_abort();
        test_back_to_back();
`ifdef TRUNC_SEQ_STALL_EN
        test_stall();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/trunc_avg_sequencer.md
# trunc_avg_sequencer

Sequences element-wise averaging of two signed 8-bit vectors through one external truncated adder, where sum_trunc = (a + b + c0) >> 1. Runs a three-stage pipeline of operand read, adder operand registers and result write, at one element per cycle. Sits between the vector register file read and write ports and the shared adder instance.

## Interface
Parameters:
- MAX_LEN, 16: maximum vector length in elements.
- ADDR_W, 4: element address width; 2**ADDR_W >= MAX_LEN.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  command strobe; sampled only when not busy.
- len  in  ADDR_W+1  element count; 0 is legal; values above MAX_LEN clamp to MAX_LEN.
- round  in  1  carry-in for the whole command; latched at start.
- busy  out  1  high while a command is in flight.
- done  out  1  one-cycle completion pulse.
- rd_en  out  1  operand read request.
- rd_addr  out  ADDR_W  operand element index.
- a_data, b_data  in  8 each, signed  operand read data; valid the cycle after rd_en.
- add_a, add_b  out  8 each, signed  registered adder operands.
- add_c0  out  1  adder carry-in; equals the latched round.
- add_sum  in  8, signed  combinational adder result for add_a/add_b/add_c0.
- wr_en  out  1  result write strobe.
- wr_addr  out  ADDR_W  result element index.
- wr_data  out  8, signed  registered copy of add_sum.
- wr_ready  in  1  write acceptance; present only with TRUNC_SEQ_STALL_EN.

## Operation
- Reset: every output is 0, the FSM is in IDLE and all indices are 0. Asserting rst_n low mid-command aborts it immediately. No further rd_en, wr_en or done is issued.
- FSM states:
  - IDLE: on start, latch the clamped len into cnt and latch round. If cnt=0, go to DONE; otherwise go to RUN.
  - RUN: issue rd_en with rd_addr=issue_idx and increment issue_idx. After issuing index cnt-1, go to DRAIN.
  - DRAIN: no reads. When the write of index cnt-1 is accepted, go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Pipeline:
  - Stage 1: the read is issued.
  - Stage 2: a_data/b_data are captured into add_a/add_b, and an op_valid flag is set.
  - Stage 3: wr_data<=add_sum, wr_addr<=the index of that element, and wr_en<=op_valid.
- Writes go out in strictly ascending index order, one per element. Write indices equal read indices.
- add_a, add_b and add_c0 hold their last values when idle. They are not cleared between commands, except by reset.
- busy=1 in RUN and DRAIN, and 0 in IDLE and DONE.
- start while busy is ignored.
- start during the DONE cycle is not accepted. It is sampled again in the following IDLE cycle if still high.
- Arithmetic is owned by the external adder. The block never modifies add_sum; wr_data is add_sum verbatim.

## Timing
- Cycle 0: start is sampled high in IDLE.
- Cycle 1 through cycle N: rd_en=1, with rd_addr running 0 through N-1.
- Element k:
  - read data returns in cycle k+2.
  - add_a/add_b are valid in cycle k+3.
  - wr_en is valid in cycle k+4.
- Last write occurs in cycle N+3.
- done is high in cycle N+4 and busy is low in that cycle.
- Throughput: 1 element per cycle. Latency per element: 3 cycles from rd_en to wr_en.
- len=0: done in cycle 1, with no reads and no writes.
- len=1: rd_en in cycle 1, wr_en in cycle 4, done in cycle 5.

## Configuration
- TRUNC_SEQ_STALL_EN defined:
  - The wr_ready port exists. A write is accepted when wr_en and wr_ready are both high.
  - While wr_en=1 and wr_ready=0:
    - wr_en, wr_addr and wr_data hold.
    - The operand registers hold.
    - rd_en is forced to 0 and issue_idx freezes.
  - Read data already in flight from the previous cycle's rd_en is captured in a one-entry skid register, so no element is lost or duplicated.
  - Once wr_ready returns high, flow resumes in order. The skid entry drains before the next read data is consumed.
  - done fires only after the last write is accepted.
- Undefined: no wr_ready port. Every wr_en is accepted in its cycle and the timing above is exact.

## Test plan
- round=0, len=4, a=[10,-10,127,-128], b=[20,-11,127,-128] -> writes to addr 0..3 of [15,-11,127,-128], done in cycle 8.
- round=1, len=2, a=[1,-3], b=[2,0] -> writes [2,-1]; add_c0=1 throughout.
- len=0 -> done in cycle 1; rd_en and wr_en never assert. A separate run with len=20 (MAX_LEN=16) -> exactly 16 reads and 16 writes.
- Assert rst_n low in cycle 3 of a len=8 command -> all outputs 0 asynchronously; no writes after release; no done.
- A start pulse while busy, then a back-to-back start one cycle after done -> the first is ignored and the second runs normally.
- With TRUNC_SEQ_STALL_EN: len=6, wr_ready low in cycles 5-7 -> six writes in order at addr 0..5 with correct data, and rd_en low during the stall. done comes 3 cycles later than in the unstalled case.
